// File: rtl/sync_fifo_lvl_pkg.sv
// sync_fifo_lvl_pkg: shared depth helper and default thresholds for the sync_fifo_lvl FIFO family
package sync_fifo_lvl_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_AEMPTY_THR = 4;
  localparam int DEF_AFULL_MARGIN = 4;
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: simple dual-port block RAM with registered read port
module sync_fifo_ram #(
  parameter int data_width = 16,
  parameter int addr_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic                  re,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] q
);
  logic [data_width-1:0] mem [2**addr_width];
  // storage array, never reset so it maps onto block RAM
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // output register, read-before-write on address collision
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (re) q <= mem[raddr];
endmodule

// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: single-clock FIFO with level, almost flags and sticky errors; SYNC_FIFO_FWFT_EN selects show-ahead reads
module sync_fifo_lvl
  import sync_fifo_lvl_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int addr_width = DEF_ADDR_WIDTH,
  parameter int afull_thr  = fifo_depth(addr_width) - DEF_AFULL_MARGIN,
  parameter int aempty_thr = DEF_AEMPTY_THR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] wdata,
  input  logic                  winc,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  rinc,
  output logic [data_width-1:0] rdata,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [addr_width:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);
  localparam logic [addr_width:0] DEPTH = (addr_width+1)'(fifo_depth(addr_width));
  localparam logic [addr_width:0] AF = (addr_width+1)'(afull_thr);
  localparam logic [addr_width:0] AE = (addr_width+1)'(aempty_thr);
  logic [addr_width:0] wptr, rptr, wptr_n, rptr_n, level_n;
  logic wr_acc, rd_acc;
  // accepted transfers use the registered flags, so no input reaches an output combinationally
  always_comb begin
    wr_acc = winc && !wfull;
    rd_acc = rinc && !rempty;
    wptr_n = wr_acc ? wptr + 1'b1 : wptr;
    rptr_n = rd_acc ? rptr + 1'b1 : rptr;
    level_n = wptr_n - rptr_n;
  end
  // pointers, level and every status flag are registered from the post-edge state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      wfull <= 1'b0;
      rempty <= 1'b1;
      walmost_full <= AF == '0;
      ralmost_empty <= 1'b1;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      level <= level_n;
      wfull <= level_n == DEPTH;
      rempty <= level_n == '0;
      walmost_full <= level_n >= AF;
      ralmost_empty <= level_n <= AE;
      overflow <= (winc && wfull) || (overflow && !err_clr);
      underflow <= (rinc && rempty) || (underflow && !err_clr);
    end
`ifdef SYNC_FIFO_FWFT_EN
  logic [data_width-1:0] ram_q, byp;
  logic byp_sel;
  sync_fifo_ram #(.data_width(data_width), .addr_width(addr_width)) u_ram (
    .clk(clk), .rst(rst), .we(wr_acc), .waddr(wptr[addr_width-1:0]), .wdata(wdata),
    .re(1'b1), .raddr(rptr_n[addr_width-1:0]), .q(ram_q)
  );
  // the RAM returns stale data when the word written this edge is the next head, so capture it directly
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      byp_sel <= 1'b0;
      byp <= '0;
    end else begin
      byp_sel <= wr_acc && wptr[addr_width-1:0] == rptr_n[addr_width-1:0];
      byp <= wdata;
    end
  assign rdata = byp_sel ? byp : ram_q;
`else
  sync_fifo_ram #(.data_width(data_width), .addr_width(addr_width)) u_ram (
    .clk(clk), .rst(rst), .we(wr_acc), .waddr(wptr[addr_width-1:0]), .wdata(wdata),
    .re(rd_acc), .raddr(rptr[addr_width-1:0]), .q(rdata)
  );
`endif
endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb_sync_fifo_lvl: directed self-checking bench for sync_fifo_lvl (both read modes via SYNC_FIFO_FWFT_EN)
module tb_sync_fifo_lvl;
  logic clk = 1'b0, rst = 1'b1, winc = 1'b0, rinc = 1'b0, err_clr = 1'b0;
  logic [15:0] wdata = '0, rdata;
  logic wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
  logic [8:0] level;
  int vectors = 0, errors = 0;

  sync_fifo_lvl #(.data_width(16), .addr_width(8), .afull_thr(252), .aempty_thr(4)) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(wfull), .walmost_full(walmost_full),
    .rinc(rinc), .rdata(rdata), .rempty(rempty), .ralmost_empty(ralmost_empty), .level(level),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input int first, input int n);
    winc = 1'b1;
    for (int i = 0; i < n; i++) begin
      wdata = 16'(first + i);
      step();
    end
    winc = 1'b0;
  endtask

  task automatic pop_burst(input int first, input int n, input string name);
    rinc = 1'b1;
    for (int i = 0; i < n; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      vectors++;
      if (rdata !== 16'(first + i)) begin errors++; $display("FAIL %s[%0d] rdata got %h want %h", name, i, rdata, 16'(first + i)); end
      step();
`else
      step();
      vectors++;
      if (rdata !== 16'(first + i)) begin errors++; $display("FAIL %s[%0d] rdata got %h want %h", name, i, rdata, 16'(first + i)); end
`endif
    end
    rinc = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    vectors++;
    if ({level, rempty, wfull, ralmost_empty, walmost_full, overflow, underflow} !== {9'd0, 6'b101000}) begin
      errors++; $display("FAIL reset_flags got lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b want lvl=0 e=1 f=0 ae=1 af=0 ov=0 un=0",
        level, rempty, wfull, ralmost_empty, walmost_full, overflow, underflow);
    end
    vectors++;
    if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h want 0000", rdata); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_midstream();
    write_burst(16'h0500, 5);
    vectors++;
    if (level !== 9'd5 || ralmost_empty !== 1'b0) begin errors++; $display("FAIL mid_pre got lvl=%0d ae=%b want lvl=5 ae=0", level, ralmost_empty); end
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({level, rempty, wfull, ralmost_empty, walmost_full, overflow, underflow} !== {9'd0, 6'b101000} || rdata !== 16'h0) begin
      errors++; $display("FAIL mid_async got lvl=%0d e=%b ae=%b rdata=%h want lvl=0 e=1 ae=1 rdata=0000", level, rempty, ralmost_empty, rdata);
    end
    #2 rst = 1'b0;
    step();
    wdata = 16'h0111; winc = 1'b1; step();
    wdata = 16'h0222; step(); winc = 1'b0;
    vectors++;
    if (level !== 9'd2) begin errors++; $display("FAIL mid_level got %0d want 2", level); end
    pop_burst(16'h0111, 1, "mid_first");
    pop_burst(16'h0222, 1, "mid_second");
    vectors++;
    if (rempty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b want 1", rempty); end
  endtask

  task automatic test_fill_drain();
    write_burst(0, 256);
    vectors++;
    if (wfull !== 1'b1 || level !== 9'd256 || walmost_full !== 1'b1) begin
      errors++; $display("FAIL fill_full got f=%b lvl=%0d af=%b want f=1 lvl=256 af=1", wfull, level, walmost_full);
    end
    wdata = 16'hDEAD; winc = 1'b1; step(); winc = 1'b0;
    vectors++;
    if (level !== 9'd256 || overflow !== 1'b1) begin errors++; $display("FAIL fill_extra got lvl=%0d ov=%b want lvl=256 ov=1", level, overflow); end
    pop_burst(0, 256, "drain");
    vectors++;
    if (rempty !== 1'b1 || level !== 9'd0 || underflow !== 1'b0) begin
      errors++; $display("FAIL drain_end got e=%b lvl=%0d un=%b want e=1 lvl=0 un=0", rempty, level, underflow);
    end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL fill_clr got ov=%b want 0", overflow); end
  endtask

  task automatic test_thresholds();
    winc = 1'b1;
    for (int n = 1; n <= 252; n++) begin
      wdata = 16'(n);
      step();
      if (n == 4 || n == 5) begin
        vectors++;
        if (ralmost_empty !== (n == 4)) begin errors++; $display("FAIL thr_ae_up lvl=%0d got %b want %b", n, ralmost_empty, n == 4); end
      end
      if (n == 251 || n == 252) begin
        vectors++;
        if (walmost_full !== (n == 252)) begin errors++; $display("FAIL thr_af_up lvl=%0d got %b want %b", n, walmost_full, n == 252); end
      end
    end
    winc = 1'b0;
    rinc = 1'b1;
    for (int n = 251; n >= 0; n--) begin
      step();
      if (n == 251 || n == 5 || n == 4) begin
        vectors++;
        if (walmost_full !== 1'b0 || ralmost_empty !== (n == 4) || level !== 9'(n)) begin
          errors++; $display("FAIL thr_down lvl=%0d got lvl=%0d af=%b ae=%b want af=0 ae=%b", n, level, walmost_full, ralmost_empty, n == 4);
        end
      end
    end
    rinc = 1'b0;
  endtask

  task automatic test_simultaneous();
    write_burst(16'h1000, 256);
    wdata = 16'hBEEF; winc = 1'b1; rinc = 1'b1; step(); winc = 1'b0; rinc = 1'b0;
    vectors++;
    if (level !== 9'd255 || overflow !== 1'b1 || wfull !== 1'b0) begin
      errors++; $display("FAIL sim_full got lvl=%0d ov=%b f=%b want lvl=255 ov=1 f=0", level, overflow, wfull);
    end
    pop_burst(16'h1001, 255, "sim_drain");
    wdata = 16'h4242; winc = 1'b1; rinc = 1'b1; step(); winc = 1'b0; rinc = 1'b0;
    vectors++;
    if (level !== 9'd1 || underflow !== 1'b1 || rempty !== 1'b0) begin
      errors++; $display("FAIL sim_empty got lvl=%0d un=%b e=%b want lvl=1 un=1 e=0", level, underflow, rempty);
    end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL sim_clr got ov=%b un=%b want 0 0", overflow, underflow); end
    pop_burst(16'h4242, 1, "sim_last");
  endtask

  task automatic test_wrap();
    write_burst(0, 3);
    winc = 1'b1; rinc = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      wdata = 16'(k + 3);
`ifdef SYNC_FIFO_FWFT_EN
      vectors++;
      if (rdata !== 16'(k)) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", k, rdata, 16'(k)); end
      step();
`else
      step();
      vectors++;
      if (rdata !== 16'(k)) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", k, rdata, 16'(k)); end
`endif
      vectors++;
      if (level !== 9'd3) begin errors++; $display("FAIL wrap_level[%0d] got %0d want 3", k, level); end
    end
    winc = 1'b0; rinc = 1'b0;
    pop_burst(1000, 3, "wrap_tail");
  endtask

  task automatic test_back_to_back();
    wdata = 16'hA5A5; winc = 1'b1; step(); winc = 1'b0;
    vectors++;
    if (rempty !== 1'b0) begin errors++; $display("FAIL b2b_first got e=%b want 0", rempty); end
`ifdef SYNC_FIFO_FWFT_EN
    vectors++;
    if (rdata !== 16'hA5A5) begin errors++; $display("FAIL b2b_head got %h want a5a5", rdata); end
    wdata = 16'h1234; winc = 1'b1; rinc = 1'b1; step(); winc = 1'b0; rinc = 1'b0;
    vectors++;
    if (rdata !== 16'h1234 || rempty !== 1'b0 || level !== 9'd1) begin
      errors++; $display("FAIL b2b_bypass got rdata=%h e=%b lvl=%0d want 1234 0 1", rdata, rempty, level);
    end
    rinc = 1'b1; step(); rinc = 1'b0;
`else
    wdata = 16'h1234; winc = 1'b1; rinc = 1'b1; step(); winc = 1'b0; rinc = 1'b0;
    vectors++;
    if (rdata !== 16'hA5A5 || level !== 9'd1) begin errors++; $display("FAIL b2b_pop got rdata=%h lvl=%0d want a5a5 1", rdata, level); end
    step(); step();
    vectors++;
    if (rdata !== 16'hA5A5) begin errors++; $display("FAIL b2b_hold got %h want a5a5", rdata); end
    pop_burst(16'h1234, 1, "b2b_second");
`endif
    vectors++;
    if (rempty !== 1'b1 || level !== 9'd0) begin errors++; $display("FAIL b2b_end got e=%b lvl=%0d want 1 0", rempty, level); end
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_fill_drain();
    test_thresholds();
    test_simultaneous();
    test_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
